// File: rtl/dbg_inject_pkg.sv
// -----------------------------------------------------------------------------
// dbg_inject_pkg -- shared debug definitions used by the debug injector and
// the debug interface (if_debug).
//   dbg_state_e      : injector FSM states
//   DBG_NOP_DEFAULT  : default instruction word presented while draining
// -----------------------------------------------------------------------------
package dbg_inject_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CAPTURE = 2'd3
  } dbg_state_e;

  localparam logic [31:0] DBG_NOP_DEFAULT = 32'h0000_0000;

endpackage : dbg_inject_pkg

// File: rtl/dbg_req_slot.sv
// -----------------------------------------------------------------------------
// dbg_req_slot -- single-entry holding slot for a pending injection request.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : load din and mark the slot valid
//   pop        : mark the slot empty (word is left as-is)
//   flush      : discard any pending request (highest priority)
//   din        : instruction word to hold
//   valid      : slot holds a request
//   dout       : held instruction word
// -----------------------------------------------------------------------------
module dbg_req_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dout
);

  // NOTE: the word is a plain register, not a memory array, so it is reset
  // along with the valid bit; the injector guarantees a known value after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule : dbg_req_slot

// File: rtl/dbg_inject.sv
// -----------------------------------------------------------------------------
// dbg_inject -- debug instruction injector. In debug mode it replaces the
// fetch stream with one injected instruction, follows it with PIPE_DEPTH NOP
// slots so it retires, then snapshots CP0 register 23.
// Optional feature: define DBG_INJECT_QUEUE_EN to hold one pending RUN request
// that arrives while an injection is in progress (otherwise it is dropped and
// flagged in OVERRUN).
// Parameters:
//   PIPE_DEPTH  : NOP slots after the injected instruction (DRAIN cycles plus
//                 the CAPTURE cycle)
//   NOP_WORD    : word presented while idle/draining in debug mode
// Ports:
//   CPU_CLK, RESET_N : clock, asynchronous active-low reset
//   DBG_MODE         : debug mode level (synchronous)
//   RUN, IDATA       : one-cycle injection request and its instruction
//   MEM_INST         : normal instruction from memory
//   STALL            : fetch not accepting this cycle
//   CP0_R23          : live CP0 register 23
//   FETCH_INST       : instruction driven into fetch
//   BUSY             : injection in progress
//   STATUS_DATA      : CP0_R23 snapshot from the last completed injection
//   INJ_COUNT        : completed injections (wraps)
//   OVERRUN          : sticky, a RUN request was lost; cleared outside debug
// -----------------------------------------------------------------------------
module dbg_inject
  import dbg_inject_pkg::*;
#(
  parameter int          PIPE_DEPTH = 5,
  parameter logic [31:0] NOP_WORD   = DBG_NOP_DEFAULT
) (
  input  logic        CPU_CLK,
  input  logic        RESET_N,
  input  logic        DBG_MODE,
  input  logic        RUN,
  input  logic [31:0] IDATA,
  input  logic [31:0] MEM_INST,
  input  logic        STALL,
  input  logic [31:0] CP0_R23,
  output logic [31:0] FETCH_INST,
  output logic        BUSY,
  output logic [31:0] STATUS_DATA,
  output logic [7:0]  INJ_COUNT,
  output logic        OVERRUN
);

  localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  dbg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      status_q;
  logic [7:0]       count_q;
  logic             overrun_q;
  logic             capture;
  logic             overrun_set;
  logic             run_req;

  assign run_req = RUN && DBG_MODE;

`ifdef DBG_INJECT_QUEUE_EN
  logic        slot_push;
  logic        slot_pop;
  logic        slot_valid;
  logic [31:0] slot_word;

  dbg_req_slot u_slot (
    .clk   (CPU_CLK),
    .rst_n (RESET_N),
    .push  (slot_push),
    .pop   (slot_pop),
    .flush (!DBG_MODE),
    .din   (IDATA),
    .valid (slot_valid),
    .dout  (slot_word)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    capture     = 1'b0;
    overrun_set = 1'b0;
`ifdef DBG_INJECT_QUEUE_EN
    slot_push   = 1'b0;
    slot_pop    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (run_req) begin
          instr_d = IDATA;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!STALL) begin
          if (PIPE_DEPTH > 1) begin
            cnt_d   = CNT_W'(PIPE_DEPTH - 1);
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_DRAIN: begin
        // The counter reaches zero on the last non-stalled DRAIN cycle; the
        // CAPTURE cycle then presents the final NOP slot.
        if (!STALL) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_IDLE;
`ifdef DBG_INJECT_QUEUE_EN
        // Back-to-back: a held request, or one arriving right now into the
        // empty slot, goes straight to ISSUE.
        if (slot_valid) begin
          instr_d  = slot_word;
          slot_pop = 1'b1;
          state_d  = ST_ISSUE;
        end else if (run_req) begin
          instr_d = IDATA;
          state_d = ST_ISSUE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests arriving while an injection is in progress.
    if (run_req && state_q != ST_IDLE) begin
`ifdef DBG_INJECT_QUEUE_EN
      if (slot_valid)                  overrun_set = 1'b1;
      else if (state_q != ST_CAPTURE)  slot_push   = 1'b1;
`else
      overrun_set = 1'b1;
`endif
    end

    // Leaving debug mode aborts without capture; the slot flushes itself.
    if (!DBG_MODE) begin
      state_d = ST_IDLE;
      capture = 1'b0;
`ifdef DBG_INJECT_QUEUE_EN
      slot_pop = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CPU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      instr_q   <= '0;
      status_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      if (capture) begin
        status_q <= CP0_R23;
        count_q  <= count_q + 8'd1;
      end
      if (!DBG_MODE)        overrun_q <= 1'b0;
      else if (overrun_set) overrun_q <= 1'b1;
    end
  end

  assign FETCH_INST  = !DBG_MODE              ? MEM_INST :
                       (state_q == ST_ISSUE)  ? instr_q  : NOP_WORD;
  assign BUSY        = (state_q != ST_IDLE);
  assign STATUS_DATA = status_q;
  assign INJ_COUNT   = count_q;
  assign OVERRUN     = overrun_q;

endmodule : dbg_inject

// File: tb/tb_dbg_inject.sv
// -----------------------------------------------------------------------------
// tb_dbg_inject -- self-checking bench for dbg_inject: directed vector table,
// hand-written multi-cycle sequences, and randomized stimulus compared with a
// behavioural model. Honours DBG_INJECT_QUEUE_EN like the design.
// -----------------------------------------------------------------------------
module tb_dbg_inject;

  localparam int          PD  = 5;
  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef DBG_INJECT_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic        dbg_mode;
  logic        run;
  logic [31:0] idata;
  logic [31:0] mem_inst;
  logic        stall;
  logic [31:0] cp0_r23;
  logic [31:0] fetch_inst;
  logic        busy;
  logic [31:0] status_data;
  logic [7:0]  inj_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  dbg_inject #(.PIPE_DEPTH(PD), .NOP_WORD(NOP)) dut (
    .CPU_CLK     (cpu_clk),
    .RESET_N     (reset_n),
    .DBG_MODE    (dbg_mode),
    .RUN         (run),
    .IDATA       (idata),
    .MEM_INST    (mem_inst),
    .STALL       (stall),
    .CP0_R23     (cp0_r23),
    .FETCH_INST  (fetch_inst),
    .BUSY        (busy),
    .STATUS_DATA (status_data),
    .INJ_COUNT   (inj_count),
    .OVERRUN     (overrun)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        run;
    logic [31:0] idata;
    logic        stall;
    logic        dbg;
    logic [31:0] cp0;
    logic [31:0] mem;
    logic [31:0] e_fetch;
    logic        e_busy;
    logic [31:0] e_status;
    logic [7:0]  e_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [31:0] d, logic s, logic dm, logic [31:0] c,
                              logic [31:0] m, logic [31:0] ef, logic eb, logic [31:0] es,
                              logic [7:0] ec);
    vec_t v;
    v = '{run: r, idata: d, stall: s, dbg: dm, cp0: c, mem: m,
          e_fetch: ef, e_busy: eb, e_status: es, e_count: ec};
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // An injection is a position in a fixed schedule: slot 0 presents the
  // instruction, slots 1..PD-1 are NOPs that each need one unstalled cycle,
  // slot PD is the capture cycle which always takes exactly one cycle.
  bit          m_busy;
  int          m_pos;
  logic [31:0] m_instr;
  logic [31:0] m_status;
  int          m_count;
  bit          m_ovr;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_instr = '0; m_status = '0;
    m_count = 0; m_ovr = 0; m_pend.delete();
  endtask

  function automatic logic [31:0] model_fetch();
    if (!dbg_mode) return mem_inst;
    if (m_busy && m_pos == 0) return m_instr;
    return NOP;
  endfunction

  task automatic model_step();
    if (!dbg_mode) begin
      m_busy = 0;
      m_ovr  = 0;
      m_pend.delete();
    end else if (!m_busy) begin
      if (run) begin
        m_busy = 1; m_pos = 0; m_instr = idata;
      end
    end else if (m_pos == PD) begin
      m_status = cp0_r23;
      m_count  = (m_count + 1) % 256;
      if (m_pend.size() != 0) begin
        m_instr = m_pend.pop_front(); m_pos = 0;
        if (run) m_ovr = 1;
      end else if (run && QUEUE) begin
        m_instr = idata; m_pos = 0;
      end else begin
        m_busy = 0;
        if (run) m_ovr = 1;
      end
    end else begin
      if (run) begin
        if (QUEUE && m_pend.size() == 0) m_pend.push_back(idata);
        else m_ovr = 1;
      end
      if (!stall) m_pos++;
    end
  endtask

  initial begin
    logic [31:0] mm;
    logic [7:0]  cnt_b;

    reset_n = 1'b0; dbg_mode = 1'b1; run = 1'b0; idata = '0;
    mem_inst = 32'hDEAD_BEEF; stall = 1'b0; cp0_r23 = 32'hA5A5_A5A5;

    // ---- reset state ----
    #3;
    check("rst_busy",    busy,        32'd0);
    check("rst_status",  status_data, 32'd0);
    check("rst_count",   inj_count,   32'd0);
    check("rst_ovr",     overrun,     32'd0);
    check("rst_fetch_dbg", fetch_inst, NOP);
    dbg_mode = 1'b0;
    #1;
    check("rst_fetch_mem", fetch_inst, 32'hDEAD_BEEF);
    dbg_mode = 1'b1;
    #8 reset_n = 1'b1;
    step();

    // ---- table: basic injection, ignored RUN, stalled issue ----
    mm = 32'hDEAD_BEEF;
    tbl.push_back(mk(1, 32'h3404_8001, 0, 1, 32'hA5A5_A5A5, mm, NOP,          0, 32'h0, 8'd0));
    tbl.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 32'hA5A5_A5A5, mm, 32'h3404_8001, 1, 32'h0, 8'd0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 32'hA5A5_A5A5, mm, NOP, 1, 32'h0, 8'd0));
    tbl.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 32'hA5A5_A5A5, mm, NOP, 1, 32'h0, 8'd0));
    tbl.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 32'h0,         mm, NOP, 0, 32'hA5A5_A5A5, 8'd1));
    // RUN outside debug mode is ignored
    tbl.push_back(mk(1, 32'h2222_2222, 0, 0, 32'h0, 32'h1234_5678, 32'h1234_5678, 0, 32'hA5A5_A5A5, 8'd1));
    tbl.push_back(mk(0, 32'h0,         0, 1, 32'h0, mm, NOP, 0, 32'hA5A5_A5A5, 8'd1));
    // three stall cycles in ISSUE
    tbl.push_back(mk(1, 32'h1111_2222, 0, 1, 32'h0BAD_F00D, mm, NOP, 0, 32'hA5A5_A5A5, 8'd1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 32'h0, 1, 1, 32'h0BAD_F00D, mm, 32'h1111_2222, 1, 32'hA5A5_A5A5, 8'd1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 32'h0BAD_F00D, mm, 32'h1111_2222, 1, 32'hA5A5_A5A5, 8'd1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 32'h0, 0, 1, 32'h0BAD_F00D, mm, NOP, 1, 32'hA5A5_A5A5, 8'd1));
    tbl.push_back(mk(0, 32'h0, 0, 1, 32'h0BAD_F00D, mm, NOP, 0, 32'h0BAD_F00D, 8'd2));

    foreach (tbl[i]) begin
      run = tbl[i].run; idata = tbl[i].idata; stall = tbl[i].stall;
      dbg_mode = tbl[i].dbg; cp0_r23 = tbl[i].cp0; mem_inst = tbl[i].mem;
      @(negedge cpu_clk);
      check($sformatf("tbl%0d_fetch", i),  fetch_inst,  tbl[i].e_fetch);
      check($sformatf("tbl%0d_busy", i),   busy,        tbl[i].e_busy);
      check($sformatf("tbl%0d_status", i), status_data, tbl[i].e_status);
      check($sformatf("tbl%0d_count", i),  inj_count,   tbl[i].e_count);
      check($sformatf("tbl%0d_ovr", i),    overrun,     32'd0);
      step();
    end
    run = 1'b0; stall = 1'b0; dbg_mode = 1'b1;

    // ---- two RUNs two cycles apart ----
    run = 1'b1; idata = 32'h0000_0001; step();
    run = 1'b0; step();
    run = 1'b1; idata = 32'h0000_0002; step();
    run = 1'b0;
    repeat (20) step();
    cnt_b = QUEUE ? 8'd4 : 8'd3;
    check("two_run_count", inj_count, cnt_b);
    check("two_run_ovr",   overrun,   QUEUE ? 32'd0 : 32'd1);
    check("two_run_busy",  busy,      32'd0);
    dbg_mode = 1'b0; step();
    check("ovr_clear", overrun, 32'd0);
    dbg_mode = 1'b1; step();

    // ---- DBG_MODE dropped during DRAIN ----
    run = 1'b1; idata = 32'h0000_0003; step();
    run = 1'b0; step(); step();
    dbg_mode = 1'b0; mem_inst = 32'hCAFE_F00D;
    #1;
    check("abort_fetch_now", fetch_inst, 32'hCAFE_F00D);
    step();
    check("abort_busy",  busy,       32'd0);
    check("abort_fetch", fetch_inst, 32'hCAFE_F00D);
    check("abort_count", inj_count,  cnt_b);
    check("abort_ovr",   overrun,    32'd0);
    dbg_mode = 1'b1;
    repeat (10) step();
    check("abort_no_capture", inj_count, cnt_b);
    check("abort_idle",       busy,      32'd0);

    // ---- asynchronous reset mid-DRAIN ----
    run = 1'b1; idata = 32'h0000_0004; step();
    run = 1'b0; step(); step();
    check("pre_rst_busy", busy, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy",   busy,        32'd0);
    check("async_rst_status", status_data, 32'd0);
    check("async_rst_count",  inj_count,   32'd0);
    #2 reset_n = 1'b1;
    step();

    // ---- INJ_COUNT wrap ----
    for (int i = 0; i < 256; i++) begin
      cp0_r23 = 32'h5000_0000 + i;
      run = 1'b1; idata = 32'h1000_0000 + i; step();
      run = 1'b0;
      repeat (7) step();
      if (i == 254) check("count_255", inj_count, 32'd255);
    end
    check("count_wrap",   inj_count,   32'd0);
    check("wrap_status",  status_data, 32'h5000_00FF);

    // ---- randomized against the model ----
    reset_n = 1'b0; #2 reset_n = 1'b1;
    model_reset();
    step();
    for (int c = 0; c < 2000; c++) begin
      dbg_mode = ($urandom_range(0, 19) != 0);
      run      = ($urandom_range(0, 5) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      idata    = $urandom;
      cp0_r23  = $urandom;
      mem_inst = $urandom;
      @(negedge cpu_clk);
      check("rnd_fetch",  fetch_inst,  model_fetch());
      check("rnd_busy",   busy,        {31'd0, m_busy});
      check("rnd_status", status_data, m_status);
      check("rnd_count",  inj_count,   m_count);
      check("rnd_ovr",    overrun,     {31'd0, m_ovr});
      model_step();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dbg_inject
